// File: rtl/ppu_timing_gen.sv
// Raster timing generator for the PPU: dot/scanline counters, odd-frame dot skip,
// vblank status flag and NMI request. Defaults reproduce NTSC 2C02 timing.
module ppu_timing_gen #(
  parameter int DOTS_PER_LINE = 341,
  parameter int VISIBLE_LINES = 240,
  parameter int POST_LINES    = 1,
  parameter int VBLANK_LINES  = 20,
  parameter int SKIP_ODD_DOT  = 1,
  parameter int CW            = 9,
  parameter int LW            = 9
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ce,
  input  logic          render_en,
  input  logic          nmi_en,
  input  logic          status_rd,
  output logic [CW-1:0] cycle,
  output logic [LW-1:0] scanline,
  output logic          odd_frame,
  output logic          vblank_flag,
  output logic          nmi,
  output logic          visible,
  output logic          frame_end
);

  localparam logic [LW-1:0] PRE_LINE     = {LW{1'b1}};
  localparam logic [LW-1:0] VBL_LINE     = LW'(VISIBLE_LINES + POST_LINES);
  localparam logic [LW-1:0] LAST_LINE    = LW'(VISIBLE_LINES + POST_LINES + VBLANK_LINES - 1);
  localparam logic [LW-1:0] VIS_LINES    = LW'(VISIBLE_LINES);
  localparam logic [CW-1:0] LAST_DOT     = CW'(DOTS_PER_LINE - 1);
  localparam logic [CW-1:0] SKIP_DOT     = CW'(DOTS_PER_LINE - 2);
  localparam logic [CW-1:0] VIS_LAST_DOT = CW'(256);

  logic          skip_line;
  logic          line_end;
  logic          last_line;
  logic          set_evt;
  logic          clr_evt;
  logic [CW-1:0] cycle_nx;
  logic [LW-1:0] scanline_nx;
  logic          vblank_nx;

  always_comb begin
    skip_line = (SKIP_ODD_DOT != 0) && odd_frame && render_en && (scanline == PRE_LINE);
    // The full-length test is kept even on a skip line so a late render_en rise
    // can never let the dot counter run past the end of the line.
    line_end  = (cycle == LAST_DOT) || (skip_line && (cycle == SKIP_DOT));
    last_line = (scanline == LAST_LINE);
    set_evt   = ce && (scanline == VBL_LINE) && (cycle == '0);
    clr_evt   = ce && (scanline == PRE_LINE) && (cycle == '0);

    cycle_nx    = line_end ? '0 : cycle + 1'b1;
    scanline_nx = scanline;
    if (line_end) scanline_nx = last_line ? PRE_LINE : scanline + 1'b1;

    // A status read racing the set event wins, so the flag misses that whole frame.
    vblank_nx = vblank_flag;
    if (set_evt)   vblank_nx = 1'b1;
    if (clr_evt)   vblank_nx = 1'b0;
    if (status_rd) vblank_nx = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cycle       <= '0;
      scanline    <= '0;
      odd_frame   <= 1'b0;
      vblank_flag <= 1'b0;
      frame_end   <= 1'b0;
    end else begin
      frame_end   <= ce && line_end && last_line;
      vblank_flag <= vblank_nx;
      if (ce) begin
        cycle    <= cycle_nx;
        scanline <= scanline_nx;
        if (line_end && last_line) odd_frame <= ~odd_frame;
      end
    end
  end

  assign nmi     = vblank_flag & nmi_en;
  assign visible = (scanline < VIS_LINES) && (cycle != '0) && (cycle <= VIS_LAST_DOT);

endmodule

// File: tb/tb_ppu_timing_gen.sv
// Scoreboard bench for ppu_timing_gen using a reduced raster geometry so that
// several whole frames fit in a short run.
module tb_ppu_timing_gen;

  localparam int DOTS     = 300;
  localparam int VIS      = 4;
  localparam int POST     = 1;
  localparam int VBL_N    = 3;
  localparam int SKIP     = 1;
  localparam int CWB      = 9;
  localparam int LWB      = 4;
  localparam int VBL_LINE = VIS + POST;            // 5
  localparam int LAST     = VBL_LINE + VBL_N - 1;  // 7
  localparam int LINES    = LAST + 2;              // 9
  localparam int FRAME    = LINES * DOTS;          // 2700
  localparam int PRE_CODE = (1 << LWB) - 1;        // 15

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           ce = 1'b0;
  logic           render_en = 1'b0;
  logic           nmi_en = 1'b0;
  logic           status_rd = 1'b0;
  logic [CWB-1:0] cycle;
  logic [LWB-1:0] scanline;
  logic           odd_frame, vblank_flag, nmi, visible, frame_end;

  ppu_timing_gen #(
    .DOTS_PER_LINE(DOTS), .VISIBLE_LINES(VIS), .POST_LINES(POST),
    .VBLANK_LINES(VBL_N), .SKIP_ODD_DOT(SKIP), .CW(CWB), .LW(LWB)
  ) dut (
    .clk(clk), .reset(reset), .ce(ce), .render_en(render_en), .nmi_en(nmi_en),
    .status_rd(status_rd), .cycle(cycle), .scanline(scanline), .odd_frame(odd_frame),
    .vblank_flag(vblank_flag), .nmi(nmi), .visible(visible), .frame_end(frame_end)
  );

  always #5 clk = ~clk;

  typedef struct {
    int cyc;
    int line;
    bit odd;
    bit flag;
    bit nmi;
    bit vis;
    bit fe;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Reference model: position within the raster as plain integers, pre-render line = -1.
  int m_line = 0, m_dot = 0;
  bit m_odd = 0, m_flag = 0, m_fe = 0, m_armed = 0;
  bit r_en = 0, n_en = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      if (n_fail <= 30) $display("FAIL %s: actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input bit r, input bit c, input bit re, input bit rd);
    bit set_ev, clr_ev;
    int len;
    if (r) begin
      m_line = 0; m_dot = 0; m_odd = 0; m_flag = 0; m_fe = 0; m_armed = 1;
      return;
    end
    m_fe = 0;
    if (c) begin
      set_ev = (m_line == VBL_LINE) && (m_dot == 0);
      clr_ev = (m_line == -1) && (m_dot == 0);
      len = (SKIP != 0 && m_odd && re && m_line == -1) ? DOTS - 1 : DOTS;
      m_dot++;
      if (m_dot >= len) begin
        m_dot = 0;
        if (m_line == LAST) begin
          m_line = -1; m_odd = !m_odd; m_fe = 1;
        end else begin
          m_line++;
        end
      end
      if (set_ev && !rd) m_flag = 1;
      if (clr_ev) m_flag = 0;
    end
    if (rd) m_flag = 0;
  endtask

  // One clock of stimulus: drive, check the combinational nmi, advance the model, queue the expectation.
  task automatic tick(input bit r, input bit c, input bit re, input bit ne, input bit rd);
    exp_t e;
    @(negedge clk);
    reset = r; ce = c; render_en = re; nmi_en = ne; status_rd = rd;
    #1;
    if (m_armed) chk("nmi_comb", int'(nmi), int'(m_flag & ne));
    model_step(r, c, re, rd);
    e.cyc  = m_dot;
    e.line = (m_line < 0) ? PRE_CODE : m_line;
    e.odd  = m_odd;
    e.flag = m_flag;
    e.nmi  = m_flag & ne;
    e.vis  = (m_line >= 0) && (m_line < VIS) && (m_dot >= 1) && (m_dot <= 256);
    e.fe   = m_fe;
    exp_q.push_back(e);
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  task automatic run_to(input int line, input int dot, input bit toggle_ce);
    bit c = 1'b1;
    for (int k = 0; k < 20000; k++) begin
      if (m_line == line && m_dot == dot) return;
      if (toggle_ce) c = ~c;
      tick(0, c, r_en, n_en, 0);
    end
    chk("run_to_timeout", 0, 1);
  endtask

  task automatic wait_fe(output int n);
    n = 0;
    for (int k = 0; k < 4000; k++) begin
      tick(0, 1, r_en, n_en, 0);
      n++;
      settle();
      if (frame_end) return;
    end
    n = -1;
  endtask

  // Monitor: every clock after the edge, pop the prediction and compare.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("cycle",       int'(cycle),       e.cyc);
        chk("scanline",    int'(scanline),    e.line);
        chk("odd_frame",   int'(odd_frame),   int'(e.odd));
        chk("vblank_flag", int'(vblank_flag), int'(e.flag));
        chk("nmi",         int'(nmi),         int'(e.nmi));
        chk("visible",     int'(visible),     int'(e.vis));
        chk("frame_end",   int'(frame_end),   int'(e.fe));
      end
    end
  end

  initial begin
    int n;
    bit c;
    repeat (3) tick(1, 0, 0, 0, 0);
    settle();
    chk("rst_cycle", int'(cycle), 0);
    chk("rst_scanline", int'(scanline), 0);
    chk("rst_vblank", int'(vblank_flag), 0);

    // render off: first partial frame, then two full-length frames
    r_en = 0; n_en = 1;
    wait_fe(n);
    chk("first_frame_len", n, (LAST + 1) * DOTS);
    chk("odd_after_fe1", int'(odd_frame), 1);
    chk("pre_line_code", int'(scanline), PRE_CODE);
    wait_fe(n);
    chk("frame_len_noren", n, FRAME);
    chk("odd_after_fe2", int'(odd_frame), 0);

    // render on: even frame full length, odd frame one dot short
    r_en = 1;
    wait_fe(n);
    chk("frame_len_even", n, FRAME);
    chk("odd_after_fe3", int'(odd_frame), 1);
    wait_fe(n);
    chk("frame_len_odd", n, FRAME - 1);

    // vblank set with nmi enabled, then a status read mid-vblank
    n_en = 1;
    run_to(VBL_LINE, 0, 0);
    tick(0, 1, r_en, n_en, 0);
    settle();
    chk("vbl_set_flag", int'(vblank_flag), 1);
    chk("vbl_set_nmi", int'(nmi), 1);
    chk("vbl_set_cycle", int'(cycle), 1);
    run_to(VBL_LINE + 1, 10, 0);
    tick(0, 1, r_en, n_en, 1);
    settle();
    chk("rd_clr_flag", int'(vblank_flag), 0);
    chk("rd_clr_nmi", int'(nmi), 0);
    run_to(LAST, 0, 0);
    chk("rd_stays_clr", int'(vblank_flag), 0);

    // status read on the set tick suppresses the flag for the frame
    run_to(VBL_LINE, 0, 0);
    tick(0, 1, r_en, n_en, 1);
    settle();
    chk("supp_flag", int'(vblank_flag), 0);
    chk("supp_nmi", int'(nmi), 0);
    run_to(LAST, 0, 0);
    chk("supp_late_flag", int'(vblank_flag), 0);
    run_to(VBL_LINE, 0, 0);
    tick(0, 1, r_en, n_en, 0);
    settle();
    chk("next_frame_set", int'(vblank_flag), 1);

    // nmi enabled late in vblank, then the pre-render clear
    n_en = 0;
    run_to(VBL_LINE + 1, 5, 0);
    chk("late_nmi_before", int'(nmi), 0);
    n_en = 1;
    tick(0, 1, r_en, n_en, 0);
    run_to(-1, 0, 0);
    tick(0, 1, r_en, n_en, 0);
    settle();
    chk("pre_clr_flag", int'(vblank_flag), 0);
    chk("pre_clr_nmi", int'(nmi), 0);

    // reset mid-frame with ce toggling, then ce held low
    run_to(3, 200, 1);
    tick(1, 1, r_en, n_en, 0);
    settle();
    chk("mid_rst_cycle", int'(cycle), 0);
    chk("mid_rst_scanline", int'(scanline), 0);
    chk("mid_rst_odd", int'(odd_frame), 0);
    chk("mid_rst_fe", int'(frame_end), 0);
    tick(0, 1, r_en, n_en, 0);
    repeat (5) tick(0, 0, r_en, n_en, 0);
    settle();
    chk("ce_hold_cycle", int'(cycle), 1);
    chk("ce_hold_scanline", int'(scanline), 0);

    // randomized traffic
    for (int k = 0; k < 6000; k++) begin
      if ($urandom_range(0, 499) == 0) r_en = ~r_en;
      if ($urandom_range(0, 99) == 0) n_en = ~n_en;
      c = ($urandom_range(0, 3) != 0);
      tick(($urandom_range(0, 999) == 0), c, r_en, n_en, ($urandom_range(0, 49) == 0));
    end

    repeat (3) @(posedge clk);
    #3;
    chk("queue_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
